// File: rtl/serial_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for serial_tx_arbiter.
// The master modport is the arbiter's view; slave is the sources/TX view.
interface serial_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 tx_start;
   logic [7:0]           tx_data;
   logic                 tx_busy;

   modport master (
      input  req_valid, req_data, req_last, tx_busy,
      output req_ready, tx_start, tx_data
   );

   modport slave (
      output req_valid, req_data, req_last, tx_busy,
      input  req_ready, tx_start, tx_data
   );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Round-robin sharing of one byte-wide serial transmitter between NUM_REQ sources.
// Define SERIAL_ARB_PKT_LOCK_EN to keep the grant on one requester until its req_last byte.
module serial_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   serial_tx_arbiter_if.master     bus,
   output logic [IDX_W-1:0]        grant_idx,
   output logic                    active
);

   // state        | meaning
   // ST_IDLE      | waiting for tx_busy low and a valid requester
   // ST_START     | one-cycle tx_start and req_ready pulse
   // ST_WAIT_BUSY | waiting for the transmitter to raise tx_busy
   // ST_WAIT_DONE | frame in flight, waiting for tx_busy to fall

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_e;

   if (NUM_REQ < 2 || NUM_REQ > 8 || IDX_W != $clog2(NUM_REQ)) begin : g_param_check
      $error("serial_tx_arbiter: NUM_REQ must be 2..8 and IDX_W must be clog2(NUM_REQ)");
   end

   state_e           state_q, state_d;
   logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [7:0]       tx_data_q, tx_data_d;

   logic             win_found;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] cand;
   logic [7:0]       req_byte [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      assign req_byte[i]      = bus.req_data[8*i +: 8];
      assign bus.req_ready[i] = (state_q == ST_START) && (grant_idx_q == IDX_W'(i));
   end

`ifdef SERIAL_ARB_PKT_LOCK_EN
   logic lock_q, lock_d;
`else
   logic unused_req_last;
   assign unused_req_last = ^bus.req_last;
`endif

   // Scanning downward and overwriting leaves the first valid index at or after ptr_q.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
         if (bus.req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
`ifdef SERIAL_ARB_PKT_LOCK_EN
      if (lock_q) begin
         win_found = bus.req_valid[grant_idx_q];
         win_idx   = grant_idx_q;
      end
`endif
   end

   always_comb begin
      state_d     = state_q;
      grant_idx_d = grant_idx_q;
      ptr_d       = ptr_q;
      tx_data_d   = tx_data_q;
`ifdef SERIAL_ARB_PKT_LOCK_EN
      lock_d      = lock_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!bus.tx_busy && win_found) begin
               state_d     = ST_START;
               grant_idx_d = win_idx;
               tx_data_d   = req_byte[win_idx];
            end
         end
         ST_START: begin
            state_d = ST_WAIT_BUSY;
            ptr_d   = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
`ifdef SERIAL_ARB_PKT_LOCK_EN
            lock_d  = ~bus.req_last[grant_idx_q];
`endif
         end
         ST_WAIT_BUSY: begin
            if (bus.tx_busy) state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (!bus.tx_busy) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         grant_idx_q <= '0;
         ptr_q       <= '0;
         tx_data_q   <= 8'h00;
      end else begin
         state_q     <= state_d;
         grant_idx_q <= grant_idx_d;
         ptr_q       <= ptr_d;
         tx_data_q   <= tx_data_d;
      end
   end

`ifdef SERIAL_ARB_PKT_LOCK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lock_q <= 1'b0;
      else        lock_q <= lock_d;
   end
`endif

   assign bus.tx_start = (state_q == ST_START);
   assign bus.tx_data  = tx_data_q;
   assign grant_idx    = grant_idx_q;
   assign active       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: queued requesters, a behavioural TX, and a round-robin model.
// Expected packet-lock ordering follows SERIAL_ARB_PKT_LOCK_EN when it is defined.
module tb_serial_tx_arbiter;
   localparam int N  = 4;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   serial_tx_arbiter_if #(.NUM_REQ(N)) bus();
   logic [IW-1:0] grant_idx;
   logic          active;

   serial_tx_arbiter #(.NUM_REQ(N), .IDX_W(IW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .grant_idx (grant_idx),
      .active    (active)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // Each entry is {last, byte}; the front entry is what the requester offers.
   logic [8:0] rq [N][$];
   int         grant_log[$];

   int   model_ptr   = 0;
   bit   model_lock  = 0;
   int   model_owner = 0;
   int   busy_cnt    = 0;
   bit   model_busy  = 0;
   bit   force_busy  = 0;
   bit   frame_ours  = 0;
   bit   rand_frame  = 0;
   int   frame_len   = 4;
   logic [7:0] last_tx_data = 8'h00;

   assign bus.tx_busy = model_busy | force_busy;

   task automatic drive_reqs();
      for (int i = 0; i < N; i++) begin
         if (rq[i].size() != 0) begin
            bus.req_valid[i]       = 1'b1;
            bus.req_data[8*i +: 8] = rq[i][0][7:0];
            bus.req_last[i]        = rq[i][0][8];
         end else begin
            bus.req_valid[i]       = 1'b0;
            bus.req_data[8*i +: 8] = 8'h00;
            bus.req_last[i]        = 1'b0;
         end
      end
   endtask

   function automatic int predict(input logic [N-1:0] v);
      if (model_lock) return v[model_owner] ? model_owner : -1;
      for (int k = 0; k < N; k++) begin
         if (v[(model_ptr + k) % N]) return (model_ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic bit queues_empty();
      for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   // Scoreboard and transmitter model, evaluated mid-cycle.
   always @(negedge clk) begin
      int         w;
      bit         exp_active;
      logic [N-1:0] exp_rdy;
      logic [8:0] ent;
      if (rst_n) begin
         exp_active = bus.tx_start || (model_busy && frame_ours);
         tests_run++;
         if (active !== exp_active) begin
            tests_failed++;
            $display("FAIL active_flag: got %0b expected %0b at %0t", active, exp_active, $time);
         end
         if (bus.tx_start) begin
            tests_run++;
            if (busy_cnt != 0 || force_busy) begin
               tests_failed++;
               $display("FAIL start_while_busy: tx_start=1 with busy_cnt=%0d force=%0b at %0t",
                        busy_cnt, force_busy, $time);
            end
            w = predict(bus.req_valid);
            tests_run++;
            if (w < 0) begin
               tests_failed++;
               $display("FAIL unexpected_start: got start, expected none (valid=%b) at %0t",
                        bus.req_valid, $time);
            end else begin
               ent     = rq[w][0];
               exp_rdy = '0;
               exp_rdy[w] = 1'b1;
               if (bus.req_ready !== exp_rdy || grant_idx !== IW'(w) || bus.tx_data !== ent[7:0]) begin
                  tests_failed++;
                  $display("FAIL grant: got ready=%b idx=%0d data=%h expected ready=%b idx=%0d data=%h at %0t",
                           bus.req_ready, grant_idx, bus.tx_data, exp_rdy, w, ent[7:0], $time);
               end
               model_ptr = (w + 1) % N;
`ifdef SERIAL_ARB_PKT_LOCK_EN
               model_lock  = !ent[8];
               model_owner = w;
`endif
               grant_log.push_back(w);
               void'(rq[w].pop_front());
               drive_reqs();
            end
            last_tx_data = bus.tx_data;
            frame_ours   = 1'b1;
         end else begin
            tests_run++;
            if (bus.req_ready !== '0) begin
               tests_failed++;
               $display("FAIL ready_without_start: got %b expected 0 at %0t", bus.req_ready, $time);
            end
            tests_run++;
            if (bus.tx_data !== last_tx_data) begin
               tests_failed++;
               $display("FAIL tx_data_stable: got %h expected %h at %0t", bus.tx_data, last_tx_data, $time);
            end
         end
      end else begin
         last_tx_data = 8'h00;
         frame_ours   = 1'b0;
      end
      if (rst_n && bus.tx_start && busy_cnt == 0) begin
         busy_cnt   = rand_frame ? int'($urandom_range(2, 8)) : frame_len;
         model_busy = 1'b1;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) begin
            model_busy = 1'b0;
            frame_ours = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step();
      rst_n        = 1'b0;
      model_ptr    = 0;
      model_lock   = 1'b0;
      frame_ours   = 1'b0;
      last_tx_data = 8'h00;
      #3;
      rst_n = 1'b1;
   endtask

   task automatic wait_idle(output bit ok);
      int cyc = 0;
      ok = 1'b0;
      while (cyc < 3000) begin
         step();
         cyc++;
         if (queues_empty() && busy_cnt == 0) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (3) step();
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      tests_run++;
      if (bus.tx_start !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_start: got %b expected 0", bus.tx_start); end
      tests_run++;
      if (bus.req_ready !== '0) begin tests_failed++; $display("FAIL reset_req_ready: got %b expected 0", bus.req_ready); end
      tests_run++;
      if (active !== 1'b0) begin tests_failed++; $display("FAIL reset_active: got %b expected 0", active); end
      tests_run++;
      if (grant_idx !== '0) begin tests_failed++; $display("FAIL reset_grant_idx: got %0d expected 0", grant_idx); end
      tests_run++;
      if (bus.tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
      repeat (2) step();
      #2 rst_n = 1'b1;
   endtask

   task automatic test_single_byte();
      bit ok;
      int n0;
      step();
      n0 = grant_log.size();
      rq[0].push_back({1'b1, 8'h55});
      drive_reqs();
      @(negedge clk);
      tests_run++;
      if (bus.tx_start !== 1'b0) begin tests_failed++; $display("FAIL single_latency: got start=%b expected 0", bus.tx_start); end
      @(negedge clk);
      tests_run++;
      if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h55 || bus.req_ready !== 4'b0001) begin
         tests_failed++;
         $display("FAIL single_byte: got start=%b data=%h ready=%b expected 1 55 0001",
                  bus.tx_start, bus.tx_data, bus.req_ready);
      end
      wait_idle(ok);
      tests_run++;
      if (!ok || grant_log.size() - n0 != 1) begin
         tests_failed++;
         $display("FAIL single_count: got %0d grants (idle=%0b) expected 1", grant_log.size() - n0, ok);
      end
   endtask

   task automatic test_round_robin();
      bit ok;
      int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      int base;
      do_reset();
      step();
      base = grant_log.size();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) rq[i].push_back({1'b1, 8'hA0 + 8'(i)});
      drive_reqs();
      wait_idle(ok);
      tests_run++;
      if (!ok || grant_log.size() - base != 8) begin
         tests_failed++;
         $display("FAIL rr_count: got %0d grants (idle=%0b) expected 8", grant_log.size() - base, ok);
      end else begin
         for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (grant_log[base + k] != exp_order[k]) begin
               tests_failed++;
               $display("FAIL rr_order[%0d]: got %0d expected %0d", k, grant_log[base + k], exp_order[k]);
            end
         end
      end
   endtask

   task automatic test_busy_after_reset();
      bit early = 1'b0;
      bit ok;
      step();
      force_busy = 1'b1;
      rst_n      = 1'b0;
      model_ptr  = 0;
      model_lock = 1'b0;
      frame_ours = 1'b0;
      last_tx_data = 8'h00;
      rq[2].push_back({1'b1, 8'h3C});
      drive_reqs();
      #3 rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.tx_start !== 1'b0) early = 1'b1;
      end
      tests_run++;
      if (early) begin tests_failed++; $display("FAIL busy_hold: got tx_start while busy, expected none"); end
      force_busy = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.tx_start !== 1'b1 || grant_idx !== 2'd2) begin
         tests_failed++;
         $display("FAIL busy_release: got start=%b idx=%0d expected 1 2", bus.tx_start, grant_idx);
      end
      wait_idle(ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL busy_timeout: got no idle, expected idle"); end
   endtask

   task automatic test_async_reset();
      bit ok;
      int cyc = 0;
      step();
      rq[1].push_back({1'b1, 8'h9E});
      drive_reqs();
      while (!model_busy && cyc < 50) begin @(negedge clk); cyc++; end
      repeat (2) @(posedge clk);
      #2;
      tests_run++;
      if (active !== 1'b1) begin tests_failed++; $display("FAIL arst_pre_active: got %b expected 1", active); end
      rst_n        = 1'b0;
      model_ptr    = 0;
      model_lock   = 1'b0;
      frame_ours   = 1'b0;
      last_tx_data = 8'h00;
      #1;
      tests_run++;
      if (active !== 1'b0 || bus.tx_start !== 1'b0 || bus.req_ready !== '0) begin
         tests_failed++;
         $display("FAIL arst_clear: got active=%b start=%b ready=%b expected 0 0 0",
                  active, bus.tx_start, bus.req_ready);
      end
      #1 rst_n = 1'b1;
      rq[3].push_back({1'b1, 8'h77});
      drive_reqs();
      wait_idle(ok);
      tests_run++;
      if (!ok || grant_log.size() == 0 || grant_log[grant_log.size() - 1] != 3) begin
         tests_failed++;
         $display("FAIL arst_regrant: got last grant %0d (idle=%0b) expected 3",
                  grant_log.size() ? grant_log[grant_log.size() - 1] : -1, ok);
      end
   endtask

   task automatic test_gap_fairness();
      bit ok;
      int base;
      do_reset();
      step();
      base = grant_log.size();
      rq[3].push_back({1'b1, 8'h33});
      drive_reqs();
      wait_idle(ok);
      repeat (50) step();
      rq[0].push_back({1'b1, 8'h10});
      rq[3].push_back({1'b1, 8'h13});
      drive_reqs();
      wait_idle(ok);
      tests_run++;
      if (!ok || grant_log.size() - base != 3 || grant_log[base] != 3 ||
          grant_log[base + 1] != 0 || grant_log[base + 2] != 3) begin
         tests_failed++;
         $display("FAIL gap_fairness: got %0d grants starting %0d,%0d,%0d expected 3,0,3",
                  grant_log.size() - base,
                  grant_log.size() > base     ? grant_log[base]     : -1,
                  grant_log.size() > base + 1 ? grant_log[base + 1] : -1,
                  grant_log.size() > base + 2 ? grant_log[base + 2] : -1);
      end
   endtask

   task automatic test_pkt_order();
      bit ok;
      int base;
`ifdef SERIAL_ARB_PKT_LOCK_EN
      int exp_order[7] = '{1, 1, 1, 2, 0, 2, 0};
`else
      int exp_order[7] = '{1, 2, 0, 1, 2, 0, 1};
`endif
      do_reset();
      step();
      rq[0].push_back({1'b1, 8'h01});
      drive_reqs();
      wait_idle(ok);
      base = grant_log.size();
      rq[1].push_back({1'b0, 8'hB0});
      rq[1].push_back({1'b0, 8'hB1});
      rq[1].push_back({1'b1, 8'hB2});
      for (int b = 0; b < 2; b++) begin
         rq[0].push_back({1'b1, 8'hC0 + 8'(b)});
         rq[2].push_back({1'b1, 8'hD0 + 8'(b)});
      end
      drive_reqs();
      wait_idle(ok);
      tests_run++;
      if (!ok || grant_log.size() - base != 7) begin
         tests_failed++;
         $display("FAIL pkt_count: got %0d grants (idle=%0b) expected 7", grant_log.size() - base, ok);
      end else begin
         for (int k = 0; k < 7; k++) begin
            tests_run++;
            if (grant_log[base + k] != exp_order[k]) begin
               tests_failed++;
               $display("FAIL pkt_order[%0d]: got %0d expected %0d", k, grant_log[base + k], exp_order[k]);
            end
         end
      end
   endtask

   task automatic test_random();
      bit ok;
      int loaded = 0;
      int base;
      do_reset();
      base       = grant_log.size();
      rand_frame = 1'b1;
      for (int r = 0; r < 40; r++) begin
         int gap = int'($urandom_range(0, 12));
         repeat (gap) step();
         step();
         if (!bus.tx_start) begin
            int who = int'($urandom_range(0, N - 1));
            int len = int'($urandom_range(1, 3));
            for (int b = 0; b < len; b++) begin
               rq[who].push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
               loaded++;
            end
            drive_reqs();
         end
      end
      wait_idle(ok);
      rand_frame = 1'b0;
      tests_run++;
      if (!ok || grant_log.size() - base != loaded) begin
         tests_failed++;
         $display("FAIL random_drain: got %0d grants (idle=%0b) expected %0d",
                  grant_log.size() - base, ok, loaded);
      end
   endtask

   initial begin
      rst_n = 1'b1;
      drive_reqs();
      test_reset();
      test_single_byte();
      test_round_robin();
      test_busy_after_reset();
      test_async_reset();
      test_gap_fairness();
      test_pkt_order();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got no completion by %0t expected finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
